// File: rtl/atmos_light_estimator_pkg.sv
// atmos_light_estimator_pkg: FSM states, counter width and A defaults shared across the haze chain
package atmos_light_estimator_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, COMMIT} state_t;
  localparam int PIX_CNT_W = 21;
  localparam logic [7:0] A_MIN_DEF = 8'd100;
  localparam logic [7:0] A_DEFAULT_DEF = 8'd220;
endpackage

// File: rtl/atmos_light_estimator_max3_u8.sv
// max3_u8: combinational unsigned maximum of three bytes
module max3_u8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic [7:0] c_i,
  output logic [7:0] max_o
);
  logic [7:0] ab;
  always_comb begin
    ab = a_i > b_i ? a_i : b_i;
    max_o = ab > c_i ? ab : c_i;
  end
endmodule

// File: rtl/atmos_light_estimator.sv
// atmos_light_estimator: latches RGB of the brightest dark-channel pixel per frame, commits it at frame end
import atmos_light_estimator_pkg::*;
module atmos_light_estimator #(
  parameter logic [10:0] IMG_HDISP = 11'd1024,
  parameter logic [10:0] IMG_VDISP = 11'd768,
  parameter logic [7:0]  A_MIN     = A_MIN_DEF,
  parameter logic [7:0]  A_DEFAULT = A_DEFAULT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic [7:0] per_img_Dark,
  input  logic [7:0] per_img_red,
  input  logic [7:0] per_img_green,
  input  logic [7:0] per_img_blue,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic [7:0] post_img_red,
  output logic [7:0] post_img_green,
  output logic [7:0] post_img_blue,
  output logic [7:0] atmos_red,
  output logic [7:0] atmos_green,
  output logic [7:0] atmos_blue,
  output logic [7:0] atmos_A,
  output logic       atmos_valid,
  output logic       atmos_err
);
  localparam logic [PIX_CNT_W:0] NPIX = {11'd0, IMG_HDISP} * {11'd0, IMG_VDISP};
  state_t                 state_q;
  logic                   vs_q, found_q;
  logic [7:0]             dark_max_q, cand_r_q, cand_g_q, cand_b_q;
  logic [PIX_CNT_W-1:0]   pix_cnt_q;
  logic                   pix, rise, fall, cnt_ok;
  logic [7:0]             fr_d, fg_d, fb_d, a_d;
  always_comb begin
    pix = per_frame_vsync & per_frame_href & per_frame_clken;
    rise = per_frame_vsync & ~vs_q;
    fall = ~per_frame_vsync & vs_q;
    cnt_ok = {1'b0, pix_cnt_q} == NPIX;
    fr_d = cand_r_q > A_MIN ? cand_r_q : A_MIN;
    fg_d = cand_g_q > A_MIN ? cand_g_q : A_MIN;
    fb_d = cand_b_q > A_MIN ? cand_b_q : A_MIN;
  end
  max3_u8 u_max3 (.a_i(fr_d), .b_i(fg_d), .c_i(fb_d), .max_o(a_d));
  // vs_q resets high so a frame already in progress at reset release never looks like a rise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vs_q <= 1'b1;
      found_q <= 1'b0;
      dark_max_q <= '0;
      cand_r_q <= '0;
      cand_g_q <= '0;
      cand_b_q <= '0;
      pix_cnt_q <= '0;
      post_frame_vsync <= 1'b0;
      post_frame_href <= 1'b0;
      post_frame_clken <= 1'b0;
      post_img_red <= '0;
      post_img_green <= '0;
      post_img_blue <= '0;
      atmos_red <= A_DEFAULT;
      atmos_green <= A_DEFAULT;
      atmos_blue <= A_DEFAULT;
      atmos_A <= A_DEFAULT;
      atmos_valid <= 1'b0;
      atmos_err <= 1'b0;
    end else begin
      vs_q <= per_frame_vsync;
      post_frame_vsync <= per_frame_vsync;
      post_frame_href <= per_frame_href;
      post_frame_clken <= per_frame_clken;
      post_img_red <= per_img_red;
      post_img_green <= per_img_green;
      post_img_blue <= per_img_blue;
      atmos_valid <= 1'b0;
      atmos_err <= 1'b0;
      case (state_q)
        IDLE: if (rise) begin
          found_q <= 1'b0;
          dark_max_q <= '0;
          cand_r_q <= '0;
          cand_g_q <= '0;
          cand_b_q <= '0;
          pix_cnt_q <= '0;
          state_q <= ACTIVE;
        end
        ACTIVE: begin
          if (pix) begin
            pix_cnt_q <= &pix_cnt_q ? pix_cnt_q : pix_cnt_q + PIX_CNT_W'(1);
            if (!found_q || per_img_Dark > dark_max_q) begin
              found_q <= 1'b1;
              dark_max_q <= per_img_Dark;
              cand_r_q <= per_img_red;
              cand_g_q <= per_img_green;
              cand_b_q <= per_img_blue;
            end
          end
          if (fall) state_q <= COMMIT;
        end
        COMMIT: begin
          if (cnt_ok) begin
            atmos_red <= fr_d;
            atmos_green <= fg_d;
            atmos_blue <= fb_d;
            atmos_A <= a_d;
            atmos_valid <= 1'b1;
          end else atmos_err <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_atmos_light_estimator.sv
// tb_atmos_light_estimator: frame table with scoreboard of commits, plus reset and pass-through checks
module tb_atmos_light_estimator;
  localparam logic [10:0] H = 11'd16;
  localparam logic [10:0] V = 11'd4;
  logic clk = 1'b0, rst = 1'b1;
  logic vs = 1'b0, hr = 1'b0, ce = 1'b0;
  logic [7:0] dk = '0, r = '0, g = '0, b = '0;
  logic post_vs, post_hr, post_ce, a_valid, a_err;
  logic [7:0] post_r, post_g, post_b, a_r, a_g, a_b, a_a;
  atmos_light_estimator #(.IMG_HDISP(H), .IMG_VDISP(V)) dut (
    .clk(clk), .rst(rst),
    .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ce),
    .per_img_Dark(dk), .per_img_red(r), .per_img_green(g), .per_img_blue(b),
    .post_frame_vsync(post_vs), .post_frame_href(post_hr), .post_frame_clken(post_ce),
    .post_img_red(post_r), .post_img_green(post_g), .post_img_blue(post_b),
    .atmos_red(a_r), .atmos_green(a_g), .atmos_blue(a_b), .atmos_A(a_a),
    .atmos_valid(a_valid), .atmos_err(a_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    int         npix;
    int         ia;
    logic [7:0] da;
    logic [23:0] ca;
    int         ib;
    logic [7:0] db;
    logic [23:0] cb;
    logic       ok;
    logic [31:0] exp_a;
  } frame_t;
  frame_t tbl [6];
  logic [32:0] sb [$];
  int errors = 0, checks = 0;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, req, $time);
    end
  endtask
  logic [26:0] pt_exp = '0;
  logic pt_skip = 1'b1, pv_prev = 1'b0;
  logic [31:0] last_a = '0;
  int age = 100;
  always @(posedge clk) begin
    pt_exp = {vs, hr, ce, r, g, b};
    pt_skip = rst;
  end
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst && !pt_skip) chk("passthru", {post_vs, post_hr, post_ce, post_r, post_g, post_b}, pt_exp);
    if (!rst && !a_valid) chk("atmos_stable", {a_r, a_g, a_b, a_a}, last_a);
    last_a = {a_r, a_g, a_b, a_a};
    age = (pv_prev && !post_vs) ? 0 : age + 1;
    pv_prev = post_vs;
    if (a_valid || a_err) begin
      if (sb.size() == 0) chk("unexpected_commit", {a_valid, a_err}, 2'b00);
      else begin
        e = sb.pop_front();
        chk("commit_kind", {a_valid, a_err}, {e[32], ~e[32]});
        chk("commit_rgbA", {a_r, a_g, a_b, a_a}, e[31:0]);
        chk("commit_latency", age, 1);
      end
    end
  end
  task automatic step(input logic v, input logic h, input logic c, input logic [7:0] d, input logic [23:0] rgb);
    @(posedge clk);
    #2;
    vs = v; hr = h; ce = c; dk = d; {r, g, b} = rgb;
  endtask
  task automatic run_frame(input frame_t f, input int rst_at);
    int k;
    logic [7:0] d;
    logic [23:0] c;
    repeat (3) step(0, 0, 0, 8'd0, 24'd0);
    if (rst_at < 0) sb.push_back({f.ok, f.exp_a});
    repeat (2) step(1, 0, 0, 8'd0, 24'd0);
    for (int y = 0; y < int'(V); y++) begin
      for (int x = 0; x < int'(H); x++) begin
        k = y * int'(H) + x;
        if (k == rst_at) begin
          rst = 1'b1;
          #1 chk("rst_async_atmos", {a_r, a_g, a_b, a_a}, {4{8'd220}});
          repeat (2) step(1, 1, 0, 8'd0, 24'd0);
          rst = 1'b0;
        end
        // bubble with a bright dark value that must not qualify
        if (k % 7 == 3) step(1, 1, 0, 8'd255, 24'h010101);
        d = k == f.ia ? f.da : k == f.ib ? f.db : 8'd10;
        c = k == f.ia ? f.ca : k == f.ib ? f.cb : {8'(k), 8'(k + 1), 8'(k + 2)};
        step(1, 1, k < f.npix, d, c);
      end
      repeat (2) step(1, 0, 0, 8'd0, 24'd0);
    end
    repeat (5) step(0, 0, 0, 8'd0, 24'd0);
  endtask
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    tbl[0] = '{64, 37, 8'd200, {8'd230, 8'd210, 8'd205}, -1, 8'd0, 24'd0, 1'b1, {8'd230, 8'd210, 8'd205, 8'd230}};
    tbl[1] = '{64, 5, 8'd200, {8'd240, 8'd240, 8'd240}, 50, 8'd200, {8'd150, 8'd150, 8'd150}, 1'b1, {8'd240, 8'd240, 8'd240, 8'd240}};
    tbl[2] = '{64, 12, 8'd180, {8'd90, 8'd120, 8'd60}, -1, 8'd0, 24'd0, 1'b1, {8'd100, 8'd120, 8'd100, 8'd120}};
    tbl[3] = '{63, 3, 8'd250, {8'd1, 8'd2, 8'd3}, -1, 8'd0, 24'd0, 1'b0, {8'd100, 8'd120, 8'd100, 8'd120}};
    tbl[4] = '{64, 63, 8'd255, {8'd50, 8'd60, 8'd250}, -1, 8'd0, 24'd0, 1'b1, {8'd100, 8'd100, 8'd250, 8'd250}};
    tbl[5] = '{64, 0, 8'd10, {8'd200, 8'd30, 8'd100}, -1, 8'd0, 24'd0, 1'b1, {8'd200, 8'd100, 8'd100, 8'd200}};
    repeat (3) @(posedge clk);
    #2;
    chk("rst_atmos", {a_r, a_g, a_b, a_a}, {4{8'd220}});
    chk("rst_flags", {a_valid, a_err}, 2'b00);
    chk("rst_post", {post_vs, post_hr, post_ce, post_r, post_g, post_b}, 27'd0);
    rst = 1'b0;
    repeat (4) step(0, 0, 0, 8'd0, 24'd0);
    chk("idle_atmos", {a_r, a_g, a_b, a_a, a_valid}, {{4{8'd220}}, 1'b0});
    for (int i = 0; i < 6; i++) run_frame(tbl[i], -1);
    run_frame(tbl[0], 20);
    chk("after_midrst_atmos", {a_r, a_g, a_b, a_a}, {4{8'd220}});
    run_frame(tbl[1], -1);
    for (int i = 0; i < 20 && sb.size() != 0; i++) step(0, 0, 0, 8'd0, 24'd0);
    chk("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
